// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing for the PLL lock sequencer.
// Build option: PLL_BYPASS_FALLBACK_EN enables the BYPASS_RUN degraded mode.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RUN,
    FAULT,
    BYPASS_RUN
  } state_e;

  localparam int DEF_RESET_CYCLES        = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12000;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level inputs.
// Async active-high reset clears both stages to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-loss sequencer for the system PLL on the reference clock.
// Build option: PLL_BYPASS_FALLBACK_EN (exhausted retries -> BYPASS_RUN).
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_PLL_Lock,
  input  logic i_Clear_Fault,
  output logic o_PLL_Reset,
  output logic o_PLL_Bypass,
  output logic o_System_Reset,
  output logic o_Locked,
  output logic o_Fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] o_Retry_Count
);

  localparam int RW   = $clog2(MAX_RETRIES + 1);
  localparam int CMAX = max_i(RESET_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LIM   = CW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STB_LIM   = SW'(LOCK_STABLE_CYCLES);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam state_e EXHAUSTED = BYPASS_RUN;
`else
  localparam state_e EXHAUSTED = FAULT;
`endif

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (i_PLL_Lock),
    .q   (lock_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_inc;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          locked_q, locked_d;
  logic          fault_q, fault_d;

  assign retry_inc = (retry_q == RETRY_LIM) ? retry_q
                                            : retry_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = '0;
    retry_d  = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + 1'b1 : '0;
        cnt_d    = cnt_q + 1'b1;
        // A completed stable window beats a same-cycle timeout.
        if (stable_d == STB_LIM) begin
          state_d  = RUN;
          cnt_d    = '0;
          stable_d = '0;
        end else if (cnt_d == TMO_LIM) begin
          cnt_d    = '0;
          stable_d = '0;
          retry_d  = retry_inc;
          state_d  = (retry_inc < RETRY_LIM) ? PLL_RST
                                             : EXHAUSTED;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        if (i_Clear_Fault) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
`ifdef PLL_BYPASS_FALLBACK_EN
      BYPASS_RUN: begin
        if (i_Clear_Fault) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
`endif
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge.
  always_comb begin
    pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
    sys_rst_d = !((state_d == RUN) || (state_d == BYPASS_RUN));
    locked_d  = (state_d == RUN);
    fault_d   = (state_d == FAULT) || (state_d == BYPASS_RUN);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
    end
  end

`ifdef PLL_BYPASS_FALLBACK_EN
  logic byp_q, byp_d;

  assign byp_d = (state_d == BYPASS_RUN);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) byp_q <= 1'b0;
    else         byp_q <= byp_d;
  end

  assign o_PLL_Bypass = byp_q;
`else
  assign o_PLL_Bypass = 1'b0;
`endif

  assign o_PLL_Reset    = pll_rst_q;
  assign o_System_Reset = sys_rst_q;
  assign o_Locked       = locked_q;
  assign o_Fault        = fault_q;
  assign o_Retry_Count  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed table-driven bench for pll_lock_sequencer (small parameters).
// Build option: PLL_BYPASS_FALLBACK_EN switches the exhausted-retry rows.
module tb_pll_lock_sequencer;

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       clr;
  logic       pll_rst, bypass, sys_rst, locked, fault;
  logic [1:0] retry;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_CYCLES        (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (50),
    .MAX_RETRIES         (2)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_PLL_Lock     (lock),
    .i_Clear_Fault  (clr),
    .o_PLL_Reset    (pll_rst),
    .o_PLL_Bypass   (bypass),
    .o_System_Reset (sys_rst),
    .o_Locked       (locked),
    .o_Fault        (fault),
    .o_Retry_Count  (retry)
  );

  typedef struct {
    int         n;
    logic       rst;
    logic       lock;
    logic       clr;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  // exp packing: {pll_rst, sys_rst, locked, fault, bypass, retry[1:0]}
  task automatic add(input int n, input logic r, input logic l,
                     input logic c, input logic pr, input logic sr,
                     input logic lk, input logic ft, input logic bp,
                     input logic [1:0] rt);
    vec_t v;
    v.n    = n;
    v.rst  = r;
    v.lock = l;
    v.clr  = c;
    v.exp  = {pr, sr, lk, ft, bp, rt};
    tbl.push_back(v);
  endtask

  function automatic logic [6:0] outs();
    return {pll_rst, sys_rst, locked, fault, bypass, retry};
  endfunction

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_row();
    add(1, 1, 0, 0, 1, 1, 0, 0, 0, 2'd0);
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    clr  = 1'b0;

    // Clean lock, then clear pulse ignored in RUN.
    reset_row();
    add(3, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(9, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd0);
    add(1, 0, 1, 1, 0, 0, 1, 0, 0, 2'd0);
    add(2, 0, 1, 0, 0, 0, 1, 0, 0, 2'd0);

    // Glitch at stable count 5 restarts the window.
    reset_row();
    add(4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(5, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(4, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(5, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd0);

    // One timeout, lock on retry, then lock loss keeps retry=1.
    reset_row();
    add(53, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 2'd1);
    add(3, 0, 1, 0, 1, 1, 0, 0, 0, 2'd1);
    add(1, 0, 1, 0, 0, 1, 0, 0, 0, 2'd1);
    add(7, 0, 1, 0, 0, 1, 0, 0, 0, 2'd1);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 2'd1);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd1);
    add(1, 0, 1, 0, 1, 1, 0, 0, 0, 2'd1);
    add(3, 0, 1, 0, 1, 1, 0, 0, 0, 2'd1);
    add(1, 0, 1, 0, 0, 1, 0, 0, 0, 2'd1);
    add(7, 0, 1, 0, 0, 1, 0, 0, 0, 2'd1);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd1);

    // Two timeouts -> exhausted; clear restarts to RUN.
    reset_row();
    add(4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(49, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 2'd1);
    add(3, 0, 0, 0, 1, 1, 0, 0, 0, 2'd1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd1);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 2'd1);
    add(48, 0, 0, 0, 0, 1, 0, 0, 0, 2'd1);
    add(1, 0, 0, 0, !BYP, !BYP, 0, 1, BYP, 2'd2);
    add(20, 0, 0, 0, !BYP, !BYP, 0, 1, BYP, 2'd2);
    add(3, 0, 1, 0, !BYP, !BYP, 0, 1, BYP, 2'd2);
    add(1, 0, 1, 1, 1, 1, 0, 0, 0, 2'd0);
    add(3, 0, 1, 0, 1, 1, 0, 0, 0, 2'd0);
    add(1, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(7, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].rst;
      lock = tbl[i].lock;
      clr  = tbl[i].clr;
      for (int k = 0; k < tbl[i].n; k++) tick();
      chk($sformatf("row%0d", i), tbl[i].exp);
    end

    // Async reset in mid WAIT_LOCK with a nonzero retry count.
    rst  = 1'b1;
    lock = 1'b0;
    clr  = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    chk("pre_async", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("post_rst_pulse", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    tick();
    chk("post_rst_wait", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
